// File: rtl/jpeg_bitstream_packer.sv
// jpeg_bitstream_packer
//   Packs right-aligned variable-length codewords into a JPEG entropy-coded
//   byte stream. Every 0xFF data byte is followed by a stuffed 0x00, the final
//   partial byte of a frame is padded with ones, and the EOI marker
//   (0xFF 0xD9) closes the frame.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     codeword handshake
//   in_code[CODE_W]       codeword, right-aligned, bit in_len-1 sent first
//   in_len[LEN_W]         number of valid bits (0..CODE_W)
//   in_last               final beat of the frame
//   out_valid/out_ready   byte handshake
//   out_data[8]           stream byte
//   out_last              marks the 0xD9 byte of EOI
module jpeg_bitstream_packer #(
    parameter int CODE_W = 27,
    parameter int LEN_W  = 5,
    parameter int BUF_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    typedef enum logic [2:0] {RUN, STUFF, PAD, EOI_FF, EOI_D9, DONE} state_t;

    state_t           state, state_nxt;
    logic [BUF_W-1:0] acc, acc_nxt;          // MSB-aligned bit accumulator
    logic [CNT_W-1:0] cnt, cnt_nxt;          // valid bits in acc
    logic             last_seen, last_seen_nxt;

    logic             slot_free;
    logic             accept;
    logic             load;
    logic [7:0]       load_byte;
    logic             load_last;
    logic             shift8;                // top byte consumed this cycle
    logic             clr;                   // pad byte consumed the remainder
    logic [7:0]       top_byte;
    logic [7:0]       pad_byte;
    logic [CNT_W-1:0] base_cnt;
    logic [BUF_W-1:0] base_acc;
    logic [CODE_W:0]  len_mask;
    logic [CODE_W-1:0] code_m;
    logic [CNT_W-1:0] ins_sh;
    logic [BUF_W-1:0] ins_bits;

    assign slot_free = !out_valid || out_ready;
    // Registered-state only: no path from out_ready into in_ready.
    assign in_ready  = (state == RUN) && !last_seen &&
                       (cnt <= CNT_W'(BUF_W - CODE_W));
    assign accept    = in_valid && in_ready;

    assign top_byte  = acc[BUF_W-1 -: 8];
    // Only used with cnt < 8: keep the top cnt bits, fill the rest with ones.
    assign pad_byte  = top_byte | (8'hFF >> cnt[2:0]);

    // Control: what (if anything) goes into the output register this cycle.
    always_comb begin
        state_nxt     = state;
        last_seen_nxt = last_seen;
        load          = 1'b0;
        load_byte     = 8'h00;
        load_last     = 1'b0;
        shift8        = 1'b0;
        clr           = 1'b0;
        case (state)
            RUN: begin
                if (slot_free && cnt >= CNT_W'(8)) begin
                    load      = 1'b1;
                    load_byte = top_byte;
                    shift8    = 1'b1;
                    if (top_byte == 8'hFF) state_nxt = STUFF;
                end else if (last_seen && cnt < CNT_W'(8)) begin
                    state_nxt = (cnt != '0) ? PAD : EOI_FF;
                end
            end
            STUFF: begin
                if (slot_free) begin
                    load = 1'b1;
                    if (last_seen && cnt < CNT_W'(8))
                        state_nxt = (cnt != '0) ? PAD : EOI_FF;
                    else
                        state_nxt = RUN;
                end
            end
            PAD: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = pad_byte;
                    clr       = 1'b1;
                    // A padded 0xFF is still entropy data and needs stuffing.
                    state_nxt = (pad_byte == 8'hFF) ? STUFF : EOI_FF;
                end
            end
            EOI_FF: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = 8'hFF;
                    state_nxt = EOI_D9;
                end
            end
            EOI_D9: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = 8'hD9;
                    load_last = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready && out_last) begin
                    last_seen_nxt = 1'b0;
                    state_nxt     = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (accept && in_last) last_seen_nxt = 1'b1;
    end

    // Datapath: consume first, then append the new codeword below what remains.
    always_comb begin
        base_acc = acc;
        base_cnt = cnt;
        if (shift8) begin
            base_acc = acc << 8;
            base_cnt = cnt - CNT_W'(8);
        end
        if (clr) begin
            base_acc = '0;
            base_cnt = '0;
        end
        len_mask = ((CODE_W+1)'(1) << in_len) - (CODE_W+1)'(1);
        code_m   = in_code & len_mask[CODE_W-1:0];
        ins_sh   = CNT_W'(BUF_W) - base_cnt - CNT_W'(in_len);
        ins_bits = {{(BUF_W-CODE_W){1'b0}}, code_m} << ins_sh;
        acc_nxt  = base_acc;
        cnt_nxt  = base_cnt;
        if (accept) begin
            acc_nxt = base_acc | ins_bits;
            cnt_nxt = base_cnt + CNT_W'(in_len);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            acc       <= '0;
            cnt       <= '0;
            last_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            last_seen <= last_seen_nxt;
        end
    end

    // Output register: holds while stalled, refills whenever the slot frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
        end else if (slot_free) begin
            out_valid <= load;
            out_last  <= load_last;
            if (load) out_data <= load_byte;
        end
    end

endmodule

// File: doc/jpeg_bitstream_packer.md
# jpeg_bitstream_packer

Packs variable-length Huffman codewords from the entropy-coder output into a byte stream, inserting JPEG byte-stuffing (0x00 after every 0xFF in entropy-coded data), 1-padding the final partial byte, and appending the EOI marker (0xFF 0xD9) at end of frame. It sits directly downstream of the JPEG coder's compressed-stream generator and feeds the byte-wide output FIFO/DMA. Both sides use valid/ready backpressure.

## Interface
- CODE_W, 27: max codeword bits per beat (16 Huffman + 11 magnitude).
- LEN_W, 5: width of length field; must satisfy 2^LEN_W > CODE_W.
- BUF_W, 64: bit-accumulator width; must be >= CODE_W + 8.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  codeword beat valid.
- in_ready  out  1  packer can accept a beat this cycle.
- in_code  in  CODE_W  codeword, right-aligned; bit in_len-1 is sent first.
- in_len  in  LEN_W  number of valid bits, 0..CODE_W.
- in_last  in  1  final beat of the frame.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts byte.
- out_data  out  8  stream byte.
- out_last  out  1  marks the 0xD9 byte of EOI.

## Operation
- Accumulator buf[BUF_W-1:0] MSB-aligned; cnt = number of valid bits (0..BUF_W). On accept, low in_len bits of in_code go in at buf[BUF_W-1-cnt] downward; cnt += in_len. in_len = 0 is legal and has no effect except in_last.
- Beat accepted when in_valid && in_ready. in_ready = (state==RUN) && (cnt <= BUF_W-CODE_W).
- Output register slot is free when !out_valid || out_ready.
- States: RUN, STUFF, PAD, EOI_FF, EOI_D9, DONE.
- RUN: if slot free and cnt >= 8, load out_data = buf top byte, shift buf left 8, cnt -= 8. If that byte is 0xFF, go to STUFF. If last_seen, cnt < 8, and no byte is being loaded: go to PAD if cnt > 0, else EOI_FF.
- STUFF: on free slot, load 0x00. Return to RUN, or to PAD/EOI_FF under the same last_seen rule.
- PAD: on free slot, load the top cnt bits followed by (8-cnt) ones, and set cnt = 0. If the padded byte is 0xFF, go to STUFF (last_seen still set). Otherwise go to EOI_FF.
- EOI_FF: on free slot, load 0xFF with no stuffing, then go to EOI_D9.
- EOI_D9: on free slot, load 0xD9 with out_last=1, then go to DONE.
- DONE: when out_last is handshaken, clear last_seen and return to RUN. The packer is ready for the next frame.
- last_seen is set when a beat with in_last is accepted. in_ready is forced 0 from the cycle after that acceptance until RUN is re-entered.
- In the same cycle, accept and byte-load may both occur. The shift is applied first, then the new bits are appended at cnt-8.
- in_len > CODE_W is illegal and must be flagged by a bench assertion. RTL behaviour in that case is undefined.

## Timing
- Reset values: out_valid=0, out_data=0x00, out_last=0, cnt=0, buf=0, state=RUN, last_seen=0. in_ready=1 the first cycle after reset release.
- Latency: a beat accepted in cycle t that completes a byte presents that byte on out_data at t+1 at the earliest.
- Throughput: at most one byte per cycle. A stuffed 0x00 costs one extra cycle.
- While out_valid && !out_ready, out_data and out_last hold stable.
- in_ready depends only on registered state, with no combinational path from out_ready.
- Reset asserted mid-frame discards all buffered bits, a pending stuff byte, and any EOI in progress. No partial EOI is emitted.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, out_last=0, in_ready=1.
- Codes (0xAC, len 8), (0x3, len 4), (0x5, len 4), out_ready=1 -> bytes 0xAC, 0x35; no out_valid before the first accept +1.
- Stuffing: (0xFF, len 8), (0x12, len 8) -> 0xFF, 0x00, 0x12 on consecutive handshakes.
- End of frame: (0b101, len 3, in_last) -> 0xBF, 0xFF, 0xD9; out_last=1 only on 0xD9; in_ready=0 until that handshake.
- Padding to 0xFF: (0xF, len 4, in_last) -> 0xFF, 0x00, 0xFF, 0xD9 (padded byte stuffed, EOI not stuffed).
- Backpressure: stream 0xAC, 0xAC, ... at len 8 with out_ready=0 for 6 cycles -> out_data holds 0xAC stable; in_ready falls once cnt > 37; after release, every byte is delivered in order with none lost or duplicated.
